stream_fifo_fwft: RTL and testbench
===================================

# stream_fifo_fwft

Stream FIFO that joins two layers of the streaming network on the FIFO-style stream interface. It is the responder on both sides of that interface:
- It accepts writes from an upstream layer's output port (din/full_n/write).
- It presents data to a downstream layer's input port (dout/empty_n/read) in first-word-fall-through form, so a consumer may assert read combinationally from empty_n.
- An almost-full flag absorbs producers whose write strobe lags their full_n check by a fixed pipeline depth.

## Interface
- DATA_WIDTH, 8: stream word width (signed fixed point, opaque here).
- DEPTH, 16: number of entries; power of two, ≥ 4.
- AF_MARGIN, 5: prog_full_n deasserts when free slots ≤ AF_MARGIN; range 0..DEPTH-1.
- ap_clk  in  1  sole clock; all state updates on rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- din  in  DATA_WIDTH  write data, sampled with write.
- write  in  1  push request.
- full_n  out  1  1 = at least one free slot.
- prog_full_n  out  1  1 = free slots > AF_MARGIN.
- dout  out  DATA_WIDTH  head entry; valid whenever empty_n = 1.
- empty_n  out  1  1 = at least one entry held.
- read  in  1  pop request.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was issued while empty.

## Operation
- State:
  - Storage array mem[0:DEPTH-1].
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
  - Two sticky flags.
- Push accepted: write = 1 and full_n = 1.
  - mem[wr_ptr] ← din.
  - wr_ptr increments.
- Pop accepted: read = 1 and empty_n = 1.
  - rd_ptr increments.
- Next count = count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - The data order is preserved.
- Flag derivation:
  - full_n = (count != DEPTH).
  - empty_n = (count != 0).
  - prog_full_n = (DEPTH - count > AF_MARGIN).
  - All three depend only on registered state, never on write or read in the same cycle.
- Full FIFO:
  - A write is dropped even if a read happens in the same cycle.
  - The read is honoured.
  - overflow is set.
- Empty FIFO:
  - A read is ignored and underflow is set.
  - A simultaneous write is accepted.
  - There is no bypass: the data appears the next cycle.
- dout = mem[rd_ptr], driven combinationally from registered storage. Its value while empty_n = 0 is don't-care.
- Sticky flags clear only on ap_rst.
- Reset (async assert, takes effect immediately, including mid-transfer):
  - Pointers, count, overflow and underflow go to 0.
  - full_n = 1, prog_full_n = 1, empty_n = 0.
  - mem contents are not reset. dout is don't-care until the first write.
  - Any data held is discarded.

## Timing
- Write-to-read latency:
  - A push at edge N makes the entry visible on dout with empty_n = 1 after edge N.
  - A consumer can pop it at edge N+1.
- Throughput: one push and one pop per cycle, sustained, at any occupancy between 1 and DEPTH-1.
- full_n falls after the edge that brings count to DEPTH. It rises after the first pop from full.
- prog_full_n:
  - It falls after the edge where count reaches DEPTH - AF_MARGIN.
  - A producer that stops issuing new transactions when it sees prog_full_n = 0 can still land AF_MARGIN in-flight writes without overflow.
- count, full_n, empty_n and prog_full_n all change in the same cycle as one another.

## Structure
- Shared package stream_pkg:
  - typedef data_t = logic [7:0], the layer data word.
  - Default widths.
  - Function ptr_w(depth) returning $clog2(depth).
- Sub-module stream_fifo_mem:
  - Register-array storage.
  - One write port and one asynchronous read port.
  - Isolates the storage so a LUTRAM/BRAM variant can replace it later.
- Control logic (pointers, count, flags) lives in stream_fifo_fwft.

## Test plan
- Reset, then DEPTH=16 writes of 0x01..0x10 with read = 0:
  - empty_n rises after the first edge.
  - full_n falls after the 16th edge.
  - prog_full_n falls when count = 11.
  - count = 16.
  - Then read continuously: dout = 0x01..0x10 in order, empty_n = 0 after the last pop.
- Continuous write and read at count = 3 for 100 cycles with an incrementing pattern:
  - count stays at 3.
  - Output sequence equals input, delayed.
  - No flag changes.
- Fill to 16, then write 0xAA together with read:
  - 0xAA is dropped and overflow = 1.
  - count = 15.
  - The popped value is the oldest entry.
- Empty FIFO, read = 1 together with write of 0x55:
  - underflow = 1.
  - Next cycle: empty_n = 1, dout = 0x55, count = 1.
- Pointer wrap: 40 cycles of mixed random push/pop with occupancy kept in 1..15:
  - A scoreboard matches all data across the wrap boundary.
- Assert ap_rst asynchronously mid-stream with count = 7:
  - Outputs go to reset values without waiting for a clock edge: count = 0, empty_n = 0, full_n = 1, flags 0.
  - After release, the first write of 0x33 reads back as 0x33.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared word type, default widths and pointer-width helper for stream FIFOs
package stream_pkg;
  typedef logic [7:0] data_t;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int AF_MARGIN_DEF = 5;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: register-array storage, one write port and one asynchronous read port
module stream_fifo_mem import stream_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/stream_fifo_fwft.sv
// stream_fifo_fwft: first-word-fall-through stream FIFO with almost-full and sticky error flags
module stream_fifo_fwft import stream_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     write,
  output logic                     full_n,
  output logic                     prog_full_n,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     empty_n,
  input  logic                     read,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, push, pop;
  // flags come from registered count only, so consumers may gate read on empty_n
  assign full_n = count_q != CW'(DEPTH);
  assign empty_n = count_q != '0;
  assign prog_full_n = (CW'(DEPTH) - count_q) > CW'(AF_MARGIN);
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  always_comb begin
    push = write && full_n;
    pop = read && empty_n;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d = ovf_q || (write && !full_n);
    unf_d = unf_q || (read && !empty_n);
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  stream_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk(ap_clk),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(dout)
  );
endmodule

// File: tb/tb_stream_fifo_fwft.sv
// tb_stream_fifo_fwft: table-driven fill/drain vectors plus queue-model sequences for corner cases
module tb_stream_fifo_fwft;
  logic ap_clk = 1'b0, ap_rst = 1'b1, write = 1'b0, read = 1'b0;
  logic [7:0] din = '0, dout;
  logic full_n, prog_full_n, empty_n, overflow, underflow;
  logic [4:0] count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic eo = 1'b0, eu = 1'b0;

  typedef struct {
    logic wr, rd;
    logic [7:0] d;
    logic e_empty_n, e_full_n, e_pf_n;
    logic [4:0] e_count;
    logic [7:0] e_dout;
    logic dout_valid;
  } vec_t;
  vec_t vecs[32];

  stream_fifo_fwft dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din), .write(write), .full_n(full_n),
    .prog_full_n(prog_full_n), .dout(dout), .empty_n(empty_n), .read(read),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    logic do_push, do_pop;
    write = w;
    read = r;
    din = d;
    if (q.size() > 0) chk("head_dout", dout, q[0]);
    do_push = w && q.size() < 16;
    do_pop = r && q.size() > 0;
    eo = eo | (w && q.size() == 16);
    eu = eu | (r && q.size() == 0);
    @(posedge ap_clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    chk("count", count, q.size());
    chk("flags_e_f_pf", {empty_n, full_n, prog_full_n},
        {q.size() != 0, q.size() != 16, (16 - q.size()) > 5});
    chk("sticky_ovf_unf", {overflow, underflow}, {eo, eu});
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 8'(i + 1), 1'b1, i != 15, (i + 1) <= 10, 5'(i + 1), 8'h01, 1'b1};
    for (int j = 0; j < 16; j++)
      vecs[16 + j] = '{1'b0, 1'b1, 8'h00, j != 15, 1'b1, (15 - j) < 11, 5'(15 - j), 8'(j + 2), j != 15};

    #1;
    chk("rst_count", count, 0);
    chk("rst_flags_e_f_pf", {empty_n, full_n, prog_full_n}, 3'b011);
    chk("rst_sticky", {overflow, underflow}, 2'b00);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      write = vecs[i].wr;
      read = vecs[i].rd;
      din = vecs[i].d;
      @(posedge ap_clk);
      #1;
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d_flags", i), {empty_n, full_n, prog_full_n},
          {vecs[i].e_empty_n, vecs[i].e_full_n, vecs[i].e_pf_n});
      chk($sformatf("vec%0d_sticky", i), {overflow, underflow}, 2'b00);
      if (vecs[i].dout_valid) chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
    end

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
    for (int k = 0; k < 100; k++) cyc(1'b1, 1'b1, 8'(8'h83 + k));
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    chk("full_before_ovf", full_n, 1'b0);
    chk("ovf_oldest", dout, 8'h20);
    cyc(1'b1, 1'b1, 8'hAA);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", count, 15);
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);

    cyc(1'b1, 1'b1, 8'h55);
    chk("unf_set", underflow, 1'b1);
    chk("unf_empty_n", empty_n, 1'b1);
    chk("unf_dout", dout, 8'h55);
    chk("unf_count", count, 1);

    for (int k = 0; k < 40; k++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (q.size() == 1 && r && !w) w = 1'b1;
      if (q.size() == 15 && w && !r) r = 1'b1;
      cyc(w, r, 8'($urandom_range(0, 255)));
    end

    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    chk("pre_rst_count", count, 7);
    write = 1'b0;
    read = 1'b0;
    @(negedge ap_clk);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_flags_e_f_pf", {empty_n, full_n, prog_full_n}, 3'b011);
    chk("async_rst_sticky", {overflow, underflow}, 2'b00);
    q.delete();
    eo = 1'b0;
    eu = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h33);
    chk("post_rst_dout", dout, 8'h33);
    cyc(1'b0, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
